// File: rtl/clk_div_sched_pkg.sv
// Shared types and widths for the switch-programmable clock divider.
package clk_div_sched_pkg;

  localparam int DIV_W  = 8;
  localparam int STAB_W = $clog2(256);

  typedef enum logic {
    STOP = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/sw_sync_debounce.sv
// Two-flop synchronizer plus stability counter for the divisor switches.
// o_accept pulses in the cycle the held value completes STABLE_CYCLES cycles.
module sw_sync_debounce #(
  parameter int          DIV_W         = clk_div_sched_pkg::DIV_W,
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [DIV_W-1:0] i_sw,
  output logic [DIV_W-1:0] o_sw_last,
  output logic             o_accept
);

  localparam int STAB_W = clk_div_sched_pkg::STAB_W;

  logic [DIV_W-1:0]  r_sync1;
  logic [DIV_W-1:0]  r_sync2;
  logic [DIV_W-1:0]  r_sw_last;
  logic [STAB_W-1:0] r_stab_cnt;
  logic              w_same;

  assign w_same = (r_sync2 == r_sw_last);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1    <= '0;
      r_sync2    <= '0;
      r_sw_last  <= '0;
      r_stab_cnt <= '0;
    end else begin
      r_sync1 <= i_sw;
      r_sync2 <= r_sync1;
      if (!w_same) begin
        r_sw_last  <= r_sync2;
        r_stab_cnt <= '0;
      end else if (r_stab_cnt < STAB_W'(STABLE_CYCLES)) begin
        r_stab_cnt <= r_stab_cnt + STAB_W'(1);
      end
    end
  end

  // Fires exactly once per stable value: the counter saturates afterwards.
  assign o_accept  = w_same && (r_stab_cnt == STAB_W'(STABLE_CYCLES - 1));
  assign o_sw_last = r_sw_last;

endmodule

// File: rtl/clk_div_sched.sv
// Glitch-free reprogrammable clock divider: new divisors are committed only
// at a half-period boundary of oCLK, or immediately while stopped.
module clk_div_sched
  import clk_div_sched_pkg::*;
#(
  parameter int unsigned      STABLE_CYCLES = 4,
  parameter logic [DIV_W-1:0] RESET_DIV     = '0
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [DIV_W-1:0] SW,
  output logic             oCLK,
  output logic             TICK,
  output logic [DIV_W-1:0] DIV_CUR,
  output logic             PENDING
);

  localparam state_t RESET_STATE = (RESET_DIV == '0) ? STOP : RUN;

  logic [DIV_W-1:0] w_sw_last;
  logic             w_accept;

  sw_sync_debounce #(
    .DIV_W         (DIV_W),
    .STABLE_CYCLES (STABLE_CYCLES)
  ) u_sw_sync_debounce (
    .i_clk     (CLK),
    .i_rst_n   (RST_N),
    .i_sw      (SW),
    .o_sw_last (w_sw_last),
    .o_accept  (w_accept)
  );

  state_t           r_state,    w_state_next;
  logic [DIV_W-1:0] r_cnt,      w_cnt_next;
  logic [DIV_W-1:0] r_div_cur,  w_div_next;
  logic [DIV_W-1:0] r_pend_div, w_pend_div_next;
  logic             r_pending,  w_pending_next;
  logic             r_oclk,     w_oclk_next;
  logic             r_tick,     w_tick_next;
  logic             w_boundary;

  assign w_boundary = (r_state == RUN) && (r_cnt == r_div_cur - DIV_W'(1));

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state    <= RESET_STATE;
      r_cnt      <= '0;
      r_div_cur  <= RESET_DIV;
      r_pend_div <= '0;
      r_pending  <= 1'b0;
      r_oclk     <= 1'b0;
      r_tick     <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_cnt      <= w_cnt_next;
      r_div_cur  <= w_div_next;
      r_pend_div <= w_pend_div_next;
      r_pending  <= w_pending_next;
      r_oclk     <= w_oclk_next;
      r_tick     <= w_tick_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_cnt_next      = r_cnt;
    w_div_next      = r_div_cur;
    w_pend_div_next = r_pend_div;
    w_pending_next  = r_pending;
    w_oclk_next     = r_oclk;
    w_tick_next     = 1'b0;

    case (r_state)
      STOP: begin
        w_cnt_next = '0;
        if (r_pending) begin
          w_div_next     = r_pend_div;
          w_pending_next = 1'b0;
          w_state_next   = (r_pend_div == '0) ? STOP : RUN;
        end
      end
      RUN: begin
        w_cnt_next = r_cnt + DIV_W'(1);
        if (w_boundary) begin
          w_oclk_next = ~r_oclk;
          w_tick_next = 1'b1;
          w_cnt_next  = '0;
          if (r_pending) begin
            w_div_next     = r_pend_div;
            w_pending_next = 1'b0;
            w_state_next   = (r_pend_div == '0) ? STOP : RUN;
          end
        end
      end
      default: w_state_next = STOP;
    endcase

    // A same-cycle accept is judged against the divisor that will be active,
    // so a commit and a newer request never cancel each other out.
    if (w_accept) begin
      if (w_sw_last != w_div_next) begin
        w_pend_div_next = w_sw_last;
        w_pending_next  = 1'b1;
      end else begin
        w_pending_next  = 1'b0;
      end
    end
  end

  assign oCLK    = r_oclk;
  assign TICK    = r_tick;
  assign DIV_CUR = r_div_cur;
  assign PENDING = r_pending;

endmodule
